// File: rtl/frame_sink.sv
// Frame sink: measures byte-stream frames on txd/tx_en, checks length and 8-bit sum,
// and queues one summary per frame in a small FIFO with overflow drop counting.
module frame_sink #(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 2,
  parameter int SDEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  txd,
  input  logic        tx_en,
  output logic        sts_valid,
  input  logic        sts_ready,
  output logic [10:0] sts_len,
  output logic        sts_ok,
  output logic        sts_err_len,
  output logic        sts_err_sum,
  output logic [7:0]  drop_cnt,
  output logic        busy
);

  // state | meaning
  // SYNC  | after reset, wait for tx_en=0 so a partial frame is never measured
  // IDLE  | between frames, waiting for the first byte
  // RECV  | inside a frame, accumulating count and sum

  localparam int          AW    = $clog2(SDEPTH);
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  typedef enum logic [1:0] {SYNC, IDLE, RECV} state_t;

  state_t      state, state_nxt;
  logic [10:0] count, count_nxt;
  logic [7:0]  sum, sum_nxt;
  logic        push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SYNC;
      count <= '0;
      sum   <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      sum   <= sum_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    sum_nxt   = sum;
    push      = 1'b0;
    case (state)
      SYNC: if (!tx_en) state_nxt = IDLE;
      IDLE: begin
        if (tx_en) begin
          count_nxt = 11'd1;
          sum_nxt   = txd;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (tx_en) begin
          if (count != 11'h7FF) count_nxt = count + 11'd1;
          sum_nxt = sum + txd;
        end else begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  logic        err_len, err_sum;
  logic [13:0] entry;

  assign err_len = (count < MIN_L) || (count > MAX_L);
  assign err_sum = (sum != 8'h00);
  assign entry   = {count, !err_len && !err_sum, err_len, err_sum};

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [13:0] mem [SDEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, wr_en, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && sts_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < SDEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= entry;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign sts_valid = !empty;
  assign {sts_len, sts_ok, sts_err_len, sts_err_sum} = mem[rd_ptr[AW-1:0]];
  assign busy = (state == RECV);

endmodule

// File: tb/tb_frame_sink.sv
// Self-checking bench for frame_sink: directed scenarios plus random traffic,
// with a frame-level queue model checked on every falling edge.
module tb_frame_sink;

  localparam int MAX_LEN = 1518;
  localparam int MIN_LEN = 2;
  localparam int SDEPTH  = 4;

  logic        clk = 0;
  logic        rst;
  logic [7:0]  txd;
  logic        tx_en;
  logic        sts_valid;
  logic        sts_ready;
  logic [10:0] sts_len;
  logic        sts_ok;
  logic        sts_err_len;
  logic        sts_err_sum;
  logic [7:0]  drop_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  frame_sink #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .SDEPTH(SDEPTH)) dut (
    .clk(clk), .rst(rst), .txd(txd), .tx_en(tx_en),
    .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_len(sts_len),
    .sts_ok(sts_ok), .sts_err_len(sts_err_len), .sts_err_sum(sts_err_sum),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Frame-level model: inputs are stable from just after a rising edge until the next,
  // so at the falling edge we know what the coming edge will do.
  logic [13:0] exp_q[$];
  bit          m_synced;
  bit          m_in_frame;
  int          m_len;
  int          m_sum;
  int          m_drop;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_synced = 0; m_in_frame = 0; m_len = 0; m_sum = 0; m_drop = 0;
    end else begin
      checks++;
      if (sts_valid !== (exp_q.size() > 0)) begin
        errors++;
        $display("FAIL mon_valid t=%0t got %b want %b", $time, sts_valid, exp_q.size() > 0);
      end
      checks++;
      if (busy !== m_in_frame) begin
        errors++;
        $display("FAIL mon_busy t=%0t got %b want %b", $time, busy, m_in_frame);
      end
      checks++;
      if (drop_cnt !== 8'(m_drop)) begin
        errors++;
        $display("FAIL mon_drop t=%0t got %0d want %0d", $time, drop_cnt, m_drop);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if ({sts_len, sts_ok, sts_err_len, sts_err_sum} !== exp_q[0]) begin
          errors++;
          $display("FAIL mon_head t=%0t got len=%0d ok=%b el=%b es=%b want len=%0d ok=%b el=%b es=%b",
                   $time, sts_len, sts_ok, sts_err_len, sts_err_sum,
                   exp_q[0][13:3], exp_q[0][2], exp_q[0][1], exp_q[0][0]);
        end
        if (sts_ready) void'(exp_q.pop_front());
      end
      if (!m_synced) begin
        if (!tx_en) m_synced = 1;
      end else if (tx_en) begin
        m_in_frame = 1;
        m_len++;
        m_sum = (m_sum + txd) % 256;
      end else if (m_in_frame) begin
        automatic bit el = (m_len < MIN_LEN) || (m_len > MAX_LEN);
        automatic bit es = (m_sum != 0);
        automatic int sl = (m_len > 2047) ? 2047 : m_len;
        if (exp_q.size() < SDEPTH) exp_q.push_back({11'(sl), !el && !es, el, es});
        else if (m_drop < 255) m_drop++;
        m_in_frame = 0; m_len = 0; m_sum = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    tx_en = 1; txd = b;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    tx_en = 0; txd = 8'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Ends the current frame and stops at the falling edge after the push edge.
  task automatic end_frame();
    tx_en = 0;
    @(posedge clk); @(negedge clk);
  endtask

  // Sends n bytes whose 8-bit sum is zero.
  task automatic send_zero_sum(input int n);
    logic [7:0] s = 8'h00;
    logic [7:0] b;
    for (int i = 0; i < n - 1; i++) begin
      b = 8'($urandom); s = s + b; send_byte(b);
    end
    send_byte(8'h00 - s);
  endtask

  task automatic test_reset();
    rst = 1; tx_en = 1; txd = 8'hA5; sts_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sts_valid, sts_len, sts_ok, sts_err_len, sts_err_sum, drop_cnt, busy} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b len=%0d ok=%b el=%b es=%b drop=%0d busy=%b want all 0",
               sts_valid, sts_len, sts_ok, sts_err_len, sts_err_sum, drop_cnt, busy);
    end
    @(posedge clk); #1;
    rst = 0;
    send_byte(8'h11);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_sync_busy got %b want 0", busy);
    end
    idle_cycles(2);
  endtask

  task automatic test_valid_frame();
    sts_ready = 1;
    send_byte(8'h10); send_byte(8'h20); send_byte(8'hD0);
    end_frame();
    checks++;
    if ({sts_valid, sts_len, sts_ok, sts_err_len, sts_err_sum} !== {1'b1, 11'd3, 3'b100}) begin
      errors++;
      $display("FAIL valid_frame got v=%b len=%0d ok=%b el=%b es=%b want v=1 len=3 ok=1 el=0 es=0",
               sts_valid, sts_len, sts_ok, sts_err_len, sts_err_sum);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (sts_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_frame_one_cycle got %b want 0", sts_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_sum();
    sts_ready = 1;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    end_frame();
    checks++;
    if ({sts_valid, sts_len, sts_ok, sts_err_len, sts_err_sum} !== {1'b1, 11'd3, 3'b001}) begin
      errors++;
      $display("FAIL bad_sum got v=%b len=%0d ok=%b el=%b es=%b want v=1 len=3 ok=0 el=0 es=1",
               sts_valid, sts_len, sts_ok, sts_err_len, sts_err_sum);
    end
    @(posedge clk); #1;
    idle_cycles(1);
  endtask

  task automatic test_short();
    sts_ready = 1;
    send_byte(8'h00);
    end_frame();
    checks++;
    if ({sts_valid, sts_len, sts_ok, sts_err_len, sts_err_sum} !== {1'b1, 11'd1, 3'b010}) begin
      errors++;
      $display("FAIL short_frame got v=%b len=%0d ok=%b el=%b es=%b want v=1 len=1 ok=0 el=1 es=0",
               sts_valid, sts_len, sts_ok, sts_err_len, sts_err_sum);
    end
    @(posedge clk); #1;
    idle_cycles(1);
  endtask

  task automatic test_overflow();
    sts_ready = 0;
    for (int k = 0; k < 5; k++) begin
      send_zero_sum(k + 2);
      if (k < 4) idle_cycles(1);
    end
    end_frame();
    checks++;
    if ({drop_cnt, sts_valid, sts_len} !== {8'd1, 1'b1, 11'd2}) begin
      errors++;
      $display("FAIL overflow_drop got drop=%0d v=%b len=%0d want drop=1 v=1 len=2",
               drop_cnt, sts_valid, sts_len);
    end
    @(posedge clk); #1;
    sts_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({sts_valid, sts_len, sts_ok} !== {1'b1, 11'(k + 2), 1'b1}) begin
        errors++;
        $display("FAIL overflow_order_%0d got v=%b len=%0d ok=%b want v=1 len=%0d ok=1",
                 k, sts_valid, sts_len, sts_ok, k + 2);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (sts_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drained got v=%b want 0", sts_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_long();
    sts_ready = 1;
    send_zero_sum(1519);
    end_frame();
    checks++;
    if ({sts_valid, sts_len, sts_ok, sts_err_len, sts_err_sum} !== {1'b1, 11'd1519, 3'b010}) begin
      errors++;
      $display("FAIL long_1519 got v=%b len=%0d ok=%b el=%b es=%b want v=1 len=1519 ok=0 el=1 es=0",
               sts_valid, sts_len, sts_ok, sts_err_len, sts_err_sum);
    end
    @(posedge clk); #1;
    idle_cycles(1);
    send_zero_sum(1518);
    end_frame();
    checks++;
    if ({sts_valid, sts_len, sts_ok, sts_err_len, sts_err_sum} !== {1'b1, 11'd1518, 3'b100}) begin
      errors++;
      $display("FAIL long_1518 got v=%b len=%0d ok=%b el=%b es=%b want v=1 len=1518 ok=1 el=0 es=0",
               sts_valid, sts_len, sts_ok, sts_err_len, sts_err_sum);
    end
    @(posedge clk); #1;
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_frame();
    sts_ready = 1;
    send_byte(8'h33); send_byte(8'h44);
    rst = 1; tx_en = 1; txd = 8'h55;
    @(posedge clk); #1;
    rst = 0;
    send_byte(8'h66); send_byte(8'h77);
    idle_cycles(3);
    @(negedge clk);
    checks++;
    if ({sts_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_no_summary got v=%b busy=%b want v=0 busy=0", sts_valid, busy);
    end
    @(posedge clk); #1;
    send_byte(8'h10); send_byte(8'h20); send_byte(8'hD0);
    end_frame();
    checks++;
    if ({sts_valid, sts_len, sts_ok} !== {1'b1, 11'd3, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_clean got v=%b len=%0d ok=%b want v=1 len=3 ok=1",
               sts_valid, sts_len, sts_ok);
    end
    @(posedge clk); #1;
    idle_cycles(1);
  endtask

  task automatic test_back_to_back_random();
    for (int f = 0; f < 60; f++) begin
      automatic int n = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 1) begin
        sts_ready = 1'($urandom);
        send_zero_sum(n);
      end else begin
        for (int i = 0; i < n; i++) begin
          sts_ready = 1'($urandom);
          send_byte(8'($urandom));
        end
      end
      for (int g = $urandom_range(1, 3); g > 0; g--) begin
        sts_ready = 1'($urandom);
        idle_cycles(1);
      end
    end
    sts_ready = 1;
    idle_cycles(SDEPTH + 2);
    @(negedge clk);
    checks++;
    if (sts_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain got v=%b want 0", sts_valid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_sum();
    test_short();
    test_overflow();
    test_long();
    test_reset_mid_frame();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
